autocorrelation_engine: RTL and testbench



---
 rtl/autocorrelation_engine.sv | 116 +++++++++++
 tb/tb_autocorrelation_engine.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/autocorrelation_engine.sv
// autocorrelation_engine: streaming multi-lag autocorrelation with per-product
// round-toward-zero scaling, saturating accumulation and Q31 output normalisation.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last sample stream (one frame, in_last on final sample)
//   out_valid/out_ready               lag stream handshake
//   out_data/out_lag/out_last         normalised R[out_lag], last flag on lag LAGS-1
//   busy                              frame being accumulated or drained
//   sat_flag                          sticky accumulator saturation for current/last frame
module autocorrelation_engine #(
   parameter int          DATA_W   = 16,
   parameter int          ACC_W    = 32,
   parameter int          LAGS     = 11,
   parameter int          SHIFT    = 4,
   parameter int unsigned NORM_Q31 = 32'd1717986918,
   localparam int         LW       = (LAGS > 1) ? $clog2(LAGS) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic        [ACC_W-1:0]  out_data,
   output logic        [LW-1:0]     out_lag,
   output logic                     out_last,
   output logic                     busy,
   output logic                     sat_flag
);
   localparam int DD = (LAGS > 1) ? LAGS - 1 : 1;
   localparam int PW = 2 * DATA_W + 1;
   localparam logic signed [31:0] NORM_S = 32'(NORM_Q31);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

   state_t                     state_q, state_d;
   logic signed [DATA_W-1:0]   dly_q [DD];
   logic signed [DATA_W-1:0]   dly_d [DD];
   logic [LAGS-1:0][ACC_W-1:0] acc_all;
   logic [LAGS-1:0]            sat_lane;
   logic [LW-1:0]              lag_q, lag_d;
   logic                       sat_q, sat_d;
   logic                       accept, start, hs, fin;
   logic signed [ACC_W-1:0]    sel;
   logic signed [ACC_W+31:0]   scaled, biased;

   assign in_ready  = state_q != DRAIN;
   assign out_valid = state_q == DRAIN;
   assign busy      = state_q != IDLE;
   assign out_last  = out_valid && (lag_q == LW'(LAGS - 1));
   assign out_lag   = lag_q;
   assign sat_flag  = sat_q;
   assign accept    = in_valid && in_ready;
   // the first sample of a frame sees a zero history and zero accumulators
   assign start     = accept && (state_q == IDLE);
   assign hs        = out_valid && out_ready;
   assign fin       = hs && out_last;

   always_comb begin
      state_d = state_q;
      if (accept && in_last) state_d = DRAIN;
      else if (start) state_d = ACCUM;
      else if (fin) state_d = IDLE;
      lag_d = fin ? '0 : hs ? lag_q + LW'(1) : lag_q;
      sat_d = start ? (|sat_lane) : sat_q | (|sat_lane);
      dly_d[0] = accept ? in_data : dly_q[0];
      for (int i = 1; i < DD; i++) dly_d[i] = !accept ? dly_q[i] : start ? '0 : dly_q[i-1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         lag_q   <= '0;
         sat_q   <= 1'b0;
         for (int i = 0; i < DD; i++) dly_q[i] <= '0;
      end else begin
         state_q <= state_d;
         lag_q   <= lag_d;
         sat_q   <= sat_d;
         dly_q   <= dly_d;
      end
   end

   for (genvar k = 0; k < LAGS; k++) begin : g_lane
      logic signed [DATA_W-1:0] tap;
      logic signed [PW-1:0]     prod, mag, term;
      logic signed [ACC_W-1:0]  base, acc_q, acc_d;
      logic signed [ACC_W:0]    sum;
      if (k == 0) begin : g_cur
         assign tap = in_data;
      end else begin : g_dly
         assign tap = start ? '0 : dly_q[k-1];
      end
      assign prod = PW'(in_data) * PW'(tap);
      // shift the magnitude so negative products truncate toward zero
      assign mag  = prod[PW-1] ? -prod : prod;
      assign term = prod[PW-1] ? -(mag >>> SHIFT) : mag >>> SHIFT;
      assign base = start ? '0 : acc_q;
      assign sum  = (ACC_W+1)'(base) + (ACC_W+1)'(term);
      assign sat_lane[k] = accept && (sum[ACC_W] != sum[ACC_W-1]);
      assign acc_d = sat_lane[k] ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
      always_ff @(posedge clk or posedge reset) begin
         if (reset) acc_q <= '0;
         else if (accept) acc_q <= acc_d;
      end
      assign acc_all[k] = acc_q;
   end

   // y = acc * NORM / 2^31 toward zero: bias negative products before the arithmetic shift
   assign sel      = acc_all[lag_q];
   assign scaled   = (ACC_W+32)'(sel) * (ACC_W+32)'(NORM_S);
   assign biased   = scaled + (scaled[ACC_W+31] ? (ACC_W+32)'(32'sh7fff_ffff) : '0);
   assign out_data = ACC_W'(biased >>> 31);
endmodule

// File: tb/tb_autocorrelation_engine.sv
// tb_autocorrelation_engine: randomized self-checking bench against a behavioural autocorrelation model
module tb_autocorrelation_engine;
   localparam int     L  = 5;
   localparam int     SH = 4;
   localparam longint NQ = 1717986918;
   localparam longint AMAX = 64'sd2147483647;
   localparam longint AMIN = -64'sd2147483648;

   logic               clk = 1'b0;
   logic               reset, in_valid, in_last, out_ready;
   logic signed [15:0] in_data;
   logic               in_ready, out_valid, out_last, busy, sat_flag;
   logic [31:0]        out_data;
   logic [2:0]         out_lag;

   int     n_vec = 0, n_err = 0;
   longint frame [$];
   longint exp_r [L];
   bit     exp_sat;

   autocorrelation_engine #(.DATA_W(16), .ACC_W(32), .LAGS(L), .SHIFT(SH), .NORM_Q31(NQ)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_lag(out_lag), .out_last(out_last), .busy(busy), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // R[k] = sum x[n]*x[n-k], each product divided by 2^SH toward zero, clamped after every add
   task automatic model();
      longint acc [L];
      exp_sat = 0;
      for (int k = 0; k < L; k++) acc[k] = 0;
      for (int n = 0; n < frame.size(); n++)
         for (int k = 0; k < L && k <= n; k++) begin
            acc[k] += (frame[n] * frame[n-k]) / (longint'(1) << SH);
            if (acc[k] > AMAX) begin acc[k] = AMAX; exp_sat = 1; end
            else if (acc[k] < AMIN) begin acc[k] = AMIN; exp_sat = 1; end
         end
      for (int k = 0; k < L; k++) exp_r[k] = acc[k] * NQ / (longint'(1) << 31);
   endtask

   task automatic rand_frame(input int n);
      logic signed [15:0] s;
      frame = {};
      for (int i = 0; i < n; i++) begin
         s = $urandom_range(0, 1) ? 16'($urandom) : 16'(int'($urandom_range(0, 80)) - 40);
         frame.push_back(s);
      end
   endtask

   task automatic send_frame(input bit gaps);
      for (int i = 0; i < frame.size(); i++) begin
         while (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 0; in_data = 16'($urandom); in_last = 1'($urandom);
            @(negedge clk);
         end
         in_valid = 1; in_data = 16'(frame[i]); in_last = (i == frame.size() - 1);
         chk("in_ready_accum", in_ready, 1);
         if (i > 0) chk("busy_accum", busy, 1);
         @(negedge clk);
      end
      in_valid = 0; in_last = 0;
   endtask

   task automatic drain_check(input int mode);
      int got = 0, cyc = 0;
      while (got < L && cyc < 400) begin
         chk("in_ready_drain", in_ready, 0);
         chk("out_valid", out_valid, 1);
         chk("out_lag", out_lag, got);
         chk("out_data", $signed(out_data), exp_r[got]);
         chk("out_last", out_last, got == L - 1);
         chk("sat_flag", sat_flag, exp_sat);
         in_valid = 1'($urandom); in_data = 16'($urandom); in_last = 1'($urandom);
         out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2) : 1'($urandom);
         if (out_ready) got++;
         cyc++;
         @(negedge clk);
      end
      if (got < L) chk("drain_timeout", got, L);
      in_valid = 0; in_last = 0; out_ready = 0;
      chk("out_valid_after", out_valid, 0);
      chk("busy_after", busy, 0);
   endtask

   task automatic run(input bit gaps, input int mode);
      model();
      send_frame(gaps);
      drain_check(mode);
   endtask

   initial begin
      reset = 1; in_valid = 0; in_last = 0; in_data = 0; out_ready = 0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_lag", out_lag, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_sat", sat_flag, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      reset = 0;
      @(negedge clk);
      frame = '{1000, 2000, 3000}; run(0, 0);
      frame = '{-3, 5};            run(0, 0);
      frame = '{-40};              run(0, 0);
      frame = '{100};              run(0, 0);
      frame = {}; repeat (40) frame.push_back(-32768); run(0, 0);
      frame = '{1000, 2000, 3000}; run(0, 1);
      run(1, 2);
      for (int f = 0; f < 25; f++) begin
         rand_frame($urandom_range(1, 24));
         run(1'($urandom), $urandom_range(0, 2));
      end
      // abort mid-frame: the next frame must carry no residue
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_data = 16'($urandom); in_last = 0;
         @(negedge clk);
      end
      in_valid = 0;
      chk("busy_pre_reset", busy, 1);
      #3 reset = 1;
      #1 chk("busy_reset_accum", busy, 0);
      @(negedge clk) reset = 0;
      @(negedge clk);
      frame = '{1000, 2000, 3000}; run(0, 0);
      // abort mid-drain on a saturated frame
      frame = {}; repeat (40) frame.push_back(-32768);
      model();
      send_frame(0);
      out_ready = 1;
      repeat (2) @(negedge clk);
      chk("valid_pre_reset", out_valid, 1);
      chk("sat_pre_reset", sat_flag, 1);
      #3 reset = 1;
      #1 chk("valid_reset_drain", out_valid, 0);
      chk("sat_reset_drain", sat_flag, 0);
      chk("lag_reset_drain", out_lag, 0);
      chk("in_ready_reset_drain", in_ready, 1);
      @(negedge clk) reset = 0; out_ready = 0;
      @(negedge clk);
      rand_frame(7); run(1, 2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
